serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the 16-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands SLICE bits per clock, holding the inter-slice carry in a register.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the ALU datapath and a sequencer.
- Produces carry-out, signed overflow, zero and negative flags alongside the sum.

Parameters:
- WIDTH, 16, operand/result width in bits; >= 2.
- SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH, WIDTH % SLICE == 0 (elaboration error otherwise).
- NSLICE (local), WIDTH/SLICE, number of compute cycles.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  sum/difference, mod 2^WIDTH.
- cout  output  1  final carry; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zr  output  1  out == 0.
- ng  output  1  out[WIDTH-1].

Behaviour:
- One clock domain; reset_n sampled only at rising clock edges.
- Reset (reset_n=0 at an edge):
  - state=IDLE, slice counter=0, carry=0.
  - out=0, cout=0, ovf=0, out_valid=0.
  - zr/ng are derived from out, so zr=1 and ng=0.
  - in_ready = (state==IDLE) && reset_n, so it is 0 while reset_n is low and 1 from the first cycle after release.
- States:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1 at an edge, latch a and b' = sub ? ~b : b, initial carry = sub ? ~cin : cin, clear the result register, set counter=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge computes {c, s} = a[k*SLICE +: SLICE] + b'[k*SLICE +: SLICE] + carry for k = counter, writes s into out[k*SLICE +: SLICE], stores carry=c and increments the counter.
    - On slice k = NSLICE-1, additionally capture the carry into bit WIDTH-1 (c_msb_in), set cout=c and ovf = c_msb_in ^ c, then go to DONE.
  - DONE: out_valid=1; out, cout, ovf, zr, ng held stable. If out_ready=1 at an edge, go to IDLE.
- Latency: operands accepted at edge E → out_valid=1 after edge E+NSLICE.
  - WIDTH=16, SLICE=4: 4 cycles. SLICE=16: 1 cycle. SLICE=1: 16 cycles.
- Throughput: one operation per NSLICE+2 cycles minimum (accept, NSLICE compute, handshake out).
  - No overlap: in_ready=0 in RUN and DONE; in_valid there is ignored and no operands are latched.
- Inputs a, b, sub and cin may change after acceptance without affecting the result in flight.
- During RUN, out is only partially updated; it is valid solely when out_valid=1.
- Backpressure: out_ready=0 in DONE holds all outputs stable for any number of cycles.
- Reset mid-RUN or mid-DONE: the operation is abandoned, reset values apply the next cycle, and no out_valid pulse is produced.
- out_ready asserted in IDLE or RUN has no effect.

Test Plan:
- WIDTH=16, SLICE=4. a=0x1234, b=0x4321, sub=0, cin=0, accept at edge 0 → out_valid after edge 4, out=0x5555, cout=0, ovf=0, zr=0, ng=0.
- a=0x7FFF, b=0x0001 add → out=0x8000, ovf=1, ng=1, cout=0. Then a=0xFFFF, b=0x0001 → out=0x0000, cout=1, ovf=0, zr=1.
- sub=1: a=0x0005, b=0x0005, cin=0 → out=0x0000, cout=1, zr=1. Then a=0x0003, b=0x0005, cin=1 → out=0xFFFD, cout=0, ng=1.
- Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 with new operands → outputs unchanged, in_ready=0. Raise out_ready → IDLE, in_ready=1, new operands accepted next.
- Reset mid-RUN: drive reset_n=0 after 2 compute cycles → next cycle out=0, out_valid=0, state IDLE; no spurious out_valid afterwards.
- Parameter sweep (WIDTH,SLICE) = (16,1), (16,16), (8,2), (32,8) against 200 random operand/sub/cin sets each → result and flags match a reference model; latency equals WIDTH/SLICE.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: SLICE bits per clock with a registered inter-slice carry,
// operands in and results out through valid/ready handshakes.
module serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("serial_adder: illegal WIDTH/SLICE combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SLICE-1:0] a_sl_c, b_sl_c, s_sl_c;
  logic             c_sl_c, c_msb_in_c, last_c;
  int unsigned      off_c;

  // One slice of the datapath, selected by the slice counter.
  always_comb begin
    off_c      = 32'(cnt_q) * SLICE;
    a_sl_c     = a_q[off_c +: SLICE];
    b_sl_c     = b_q[off_c +: SLICE];
    {c_sl_c, s_sl_c} = {1'b0, a_sl_c} + {1'b0, b_sl_c} + {{SLICE{1'b0}}, carry_q};
    // Carry into the top bit, recovered from the top-bit sum.
    c_msb_in_c = a_sl_c[SLICE-1] ^ b_sl_c[SLICE-1] ^ s_sl_c[SLICE-1];
    last_c     = (cnt_q == CW'(NSLICE - 1));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~borrow_in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        out_d[off_c +: SLICE] = s_sl_c;
        carry_d = c_sl_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_c) begin
          cout_d  = c_sl_c;
          ovf_d   = c_msb_in_c ^ c_sl_c;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && reset_n;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zr        = (out_q == '0);
  assign ng        = out_q[WIDTH-1];

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table and corner sequences on a 16/4 instance,
// plus a randomized parameter sweep against an arithmetic reference model.
module tb_serial_adder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        sub, cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        cout, ovf, zr, ng;

  int total = 0;
  int bad   = 0;
  bit sw_done [4];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  serial_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf), .zr(zr), .ng(ng)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
  function automatic void ref_model(input int w, input longint unsigned ua, input longint unsigned ub,
                                    input bit s, input bit c, output longint unsigned o,
                                    output bit co, output bit ov);
    longint m, sa, sb, t, st;
    m  = longint'(1) << w;
    sa = (longint'(ua) >= m / 2) ? longint'(ua) - m : longint'(ua);
    sb = (longint'(ub) >= m / 2) ? longint'(ub) - m : longint'(ub);
    if (!s) begin
      t  = longint'(ua) + longint'(ub) + longint'(c);
      co = (t >= m);
      st = sa + sb + longint'(c);
    end else begin
      t  = longint'(ua) - longint'(ub) - longint'(c);
      co = (t >= 0);
      st = sa - sb - longint'(c);
    end
    o  = 64'(((t % m) + m) % m);
    ov = (st >= m / 2) || (st < -(m / 2));
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                       input logic tc, input bit release_out,
                       output logic [15:0] ro, output logic rco, output logic rov,
                       output logic rz, output logic rn, output int lat);
    @(negedge clock);
    chk("in_ready_before_op", 64'(in_ready), 64'(1));
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~ts; cin = ~tc;
    lat = 0;
    do begin
      @(posedge clock); lat++; @(negedge clock);
    end while (!out_valid && lat < 64);
    ro = out; rco = cout; rov = ovf; rz = zr; rn = ng;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] o;
    logic        co, ov, z, n;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [15:0] ro;
    logic rco, rov, rz, rn;
    int lat, seen;
    longint unsigned eo;
    bit eco, eov;
    logic [15:0] ra, rb;
    bit rs, rc;
    bit all_done;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_zr", 64'(zr), 64'(1));
    chk("rst_ng", 64'(ng), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, 1'b1, ro, rco, rov, rz, rn, lat);
      chk($sformatf("vec%0d_out", i), 64'(ro), 64'(vt[i].o));
      chk($sformatf("vec%0d_cout", i), 64'(rco), 64'(vt[i].co));
      chk($sformatf("vec%0d_ovf", i), 64'(rov), 64'(vt[i].ov));
      chk($sformatf("vec%0d_zr", i), 64'(rz), 64'(vt[i].z));
      chk($sformatf("vec%0d_ng", i), 64'(rn), 64'(vt[i].n));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(4));
      chk($sformatf("vec%0d_idle_after", i), 64'(out_valid), 64'(0));
    end

    // Backpressure in DONE with new operands offered and ignored.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, ro, rco, rov, rz, rn, lat);
    chk("bp_first_out", 64'(ro), 64'(16'h3333));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      chk("bp_hold_out", 64'(out), 64'(16'h3333));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp_accepted", 64'(in_ready), 64'(0));
    lat = 0;
    do begin
      @(posedge clock); lat++; @(negedge clock);
    end while (!out_valid && lat < 64);
    chk("bp_second_out", 64'(out), 64'(3));
    chk("bp_second_lat", 64'(lat), 64'(4));
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;

    // Reset after two compute cycles.
    chk("rr_in_ready", 64'(in_ready), 64'(1));
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rr_out", 64'(out), 64'(0));
    chk("rr_out_valid", 64'(out_valid), 64'(0));
    chk("rr_zr", 64'(zr), 64'(1));
    chk("rr_in_ready_low", 64'(in_ready), 64'(0));
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("rr_no_spurious_valid", 64'(seen), 64'(0));
    chk("rr_idle", 64'(in_ready), 64'(1));

    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      ref_model(16, 64'(ra), 64'(rb), rs, rc, eo, eco, eov);
      do_op(ra, rb, rs, rc, 1'b1, ro, rco, rov, rz, rn, lat);
      chk("rnd_out", 64'(ro), eo);
      chk("rnd_cout", 64'(rco), 64'(eco));
      chk("rnd_ovf", 64'(rov), 64'(eov));
      chk("rnd_zr", 64'(rz), 64'(eo == 0));
      chk("rnd_ng", 64'(rn), 64'(eo[15]));
    end

    all_done = 1'b0;
    for (int i = 0; i < 40000 && !all_done; i++) begin
      @(negedge clock);
      all_done = sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3];
    end
    chk("sweep_finished", 64'(all_done), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 8 : 32;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 16 : (g == 2) ? 2 : 8;

    logic         s_rst_n, s_iv, s_ir, s_sub, s_cin, s_ov_valid, s_or, s_co, s_ovf, s_zr, s_ng;
    logic [W-1:0] s_a, s_b, s_out;

    serial_adder #(.WIDTH(W), .SLICE(S)) u_sw (
      .clock(clock), .reset_n(s_rst_n), .in_valid(s_iv), .in_ready(s_ir),
      .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin), .out_valid(s_ov_valid), .out_ready(s_or),
      .out(s_out), .cout(s_co), .ovf(s_ovf), .zr(s_zr), .ng(s_ng)
    );

    initial begin
      logic [W-1:0] ra, rb;
      bit rs, rc, eco, eov;
      longint unsigned eo;
      int lat;
      sw_done[g] = 1'b0;
      s_rst_n = 1'b0; s_iv = 1'b0; s_or = 1'b0;
      s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0;
      repeat (2) @(negedge clock);
      s_rst_n = 1'b1;
      for (int t = 0; t < 200; t++) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        if (t == 0) begin ra = '1; rb = '1; end
        if (t == 1) begin ra = '0; rb = '0; end
        ref_model(W, 64'(ra), 64'(rb), rs, rc, eo, eco, eov);
        @(negedge clock);
        s_a = ra; s_b = rb; s_sub = rs; s_cin = rc; s_iv = 1'b1;
        @(posedge clock);
        @(negedge clock);
        s_iv = 1'b0; s_a = W'($urandom); s_b = W'($urandom); s_sub = ~rs; s_cin = ~rc;
        lat = 0;
        do begin
          @(posedge clock); lat++; @(negedge clock);
        end while (!s_ov_valid && lat < 64);
        chk($sformatf("sw%0d_out", g), 64'(s_out), eo);
        chk($sformatf("sw%0d_cout", g), 64'(s_co), 64'(eco));
        chk($sformatf("sw%0d_ovf", g), 64'(s_ovf), 64'(eov));
        chk($sformatf("sw%0d_zr", g), 64'(s_zr), 64'(eo == 0));
        chk($sformatf("sw%0d_ng", g), 64'(s_ng), 64'((eo >> (W - 1)) & 1));
        chk($sformatf("sw%0d_lat", g), 64'(lat), 64'(W / S));
        s_or = 1'b1;
        @(posedge clock);
        @(negedge clock);
        s_or = 1'b0;
      end
      sw_done[g] = 1'b1;
    end
  end

endmodule
